// File: rtl/period_meas_pkg.sv
// Shared types and helpers for the period_meas square-wave period counter.
package period_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  // Number of input periods that make up one measurement window.
  function automatic int unsigned win_edges(input int unsigned log2);
    return 32'd1 << log2;
  endfunction

  // Edge counter needs at least one bit even for single-period windows.
  function automatic int unsigned ecnt_width(input int unsigned log2);
    return (log2 > 32'd0) ? log2 : 32'd1;
  endfunction

endpackage

// File: rtl/period_meas_sq_sync_dg.sv
// Input conditioner: 2-flop synchroniser, optional deglitch filter, registered rise pulse.
// Deglitch filter is built only when PERIOD_MEAS_DEGLITCH_EN is defined.
module sq_sync_dg #(
  parameter int unsigned DG_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sq_i,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q, edge_d;
  logic rise_q, rise_d;
  logic lvl_s;

  if (DG_LEN < 32'd1) begin : g_dg_len_chk
    $error("DG_LEN must be at least 1");
  end

`ifdef PERIOD_MEAS_DEGLITCH_EN
  localparam int unsigned DGW = (DG_LEN > 32'd1) ? $clog2(DG_LEN) : 32'd1;
  localparam logic [DGW-1:0] DG_LAST = DGW'(DG_LEN - 32'd1);

  logic [DGW-1:0] dg_cnt_q, dg_cnt_d;
  logic           lvl_q, lvl_d;

  // Level follows the synced input only after DG_LEN consecutive differing samples.
  always_comb begin
    dg_cnt_d = {DGW{1'b0}};
    lvl_d    = lvl_q;
    if (sync2_q != lvl_q) begin
      if (dg_cnt_q == DG_LAST) begin
        lvl_d = sync2_q;
      end else begin
        dg_cnt_d = dg_cnt_q + DGW'(1'b1);
      end
    end else begin
      dg_cnt_d = {DGW{1'b0}};
    end
  end

  // Deglitch state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dg_cnt_q <= {DGW{1'b0}};
      lvl_q    <= 1'b0;
    end else begin
      dg_cnt_q <= dg_cnt_d;
      lvl_q    <= lvl_d;
    end
  end

  assign lvl_s = lvl_q;
`else
  assign lvl_s = sync2_q;
`endif

  // Synchroniser chain and edge detect.
  always_comb begin
    sync1_d = sq_i;
    sync2_d = sync1_q;
    edge_d  = lvl_s;
    rise_d  = lvl_s & ~edge_q;
  end

  // Synchroniser, edge and rise-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/period_meas.sv
// Square-wave period meter: counts clk_i cycles over 2**EDGES_LOG2 input periods.
// Optional input deglitch filter enabled by `define PERIOD_MEAS_DEGLITCH_EN.
module period_meas
  import period_meas_pkg::*;
#(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned EDGES_LOG2 = 0,
  parameter int unsigned DG_LEN     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sq_i,
  output logic             rise_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             ovf_o
);

  localparam int unsigned      ECW        = ecnt_width(EDGES_LOG2);
  localparam logic [ECW-1:0]   ECNT_LAST  = ECW'(win_edges(EDGES_LOG2) - 32'd1);
  localparam logic [ECW-1:0]   ECNT_ZERO  = {ECW{1'b0}};
  localparam logic [ECW-1:0]   ECNT_ONE   = ECW'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ECW-1:0]   ecnt_q, ecnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             rise_s;

  sq_sync_dg #(
    .DG_LEN (DG_LEN)
  ) u_sq_sync_dg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sq_i   (sq_i),
    .rise_o (rise_s)
  );

  // Next-state and result logic; completion is checked before saturation so it wins a tie.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ecnt_d   = ecnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
      ecnt_d  = ECNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = CNT_ZERO;
          ecnt_d  = ECNT_ZERO;
        end
        ARM: begin
          if (rise_s) begin
            state_d = MEAS;
            cnt_d   = CNT_ONE;
            ecnt_d  = ECNT_ZERO;
          end else begin
            state_d = ARM;
          end
        end
        MEAS: begin
          if (rise_s && (ecnt_q == ECNT_LAST)) begin
            period_d = cnt_q;
            ovf_d    = 1'b0;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            ecnt_d   = ECNT_ZERO;
          end else if (cnt_q == CNT_MAX) begin
            period_d = CNT_MAX;
            ovf_d    = 1'b1;
            valid_d  = 1'b1;
            cnt_d    = CNT_ZERO;
            ecnt_d   = ECNT_ZERO;
            state_d  = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (rise_s) begin
              ecnt_d = ecnt_q + ECNT_ONE;
            end else begin
              ecnt_d = ecnt_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          ecnt_d  = ECNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      ecnt_q   <= ECNT_ZERO;
      period_q <= CNT_ZERO;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ecnt_q   <= ecnt_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign rise_o   = rise_s;
  assign period_o = period_q;
  assign valid_o  = valid_q;
  assign ovf_o    = ovf_q;

endmodule
